pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register, the generalised successor to the fixed ID/EX control register. It carries a configurable control bundle and data bundle between two pipeline stages with valid/ready handshaking, synchronous flush (bubble insertion), and an optional two-entry skid buffer that breaks the ready path. It is instantiated at every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined RV32I core.

---
 rtl/pipe_stage_reg.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic valid/ready pipeline stage register with flush and optional skid buffer.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg #(
    parameter int                CTRL_W      = 10,
    parameter int                DATA_W      = 96,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                SKID        = 1,
    parameter int                STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    logic              w_outValid;
    logic              w_inReady;
    logic [CTRL_W-1:0] w_mainCtrl;
    logic [DATA_W-1:0] w_mainData;
    logic [STAT_W-1:0] r_stallCnt;
    logic              w_outXfer;

    assign w_outXfer = w_outValid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_nextState;
            logic              r_inReady;
            logic [CTRL_W-1:0] r_mainCtrl;
            logic [DATA_W-1:0] r_mainData;
            logic [CTRL_W-1:0] r_skidCtrl;
            logic [DATA_W-1:0] r_skidData;
            logic              w_inXfer;
            logic              w_loadMain;
            logic              w_loadSkid;
            logic              w_promote;

            assign w_inXfer = in_valid & r_inReady;

            always_comb begin
                w_nextState = r_state;
                w_loadMain  = 1'b0;
                w_loadSkid  = 1'b0;
                w_promote   = 1'b0;
                if (flush) begin
                    w_nextState = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_inXfer) begin
                                w_nextState = ST_FULL;
                                w_loadMain  = 1'b1;
                            end
                        end
                        ST_FULL: begin
                            if (w_inXfer && w_outXfer) begin
                                w_loadMain = 1'b1;
                            end else if (w_inXfer) begin
                                w_nextState = ST_SKID;
                                w_loadSkid  = 1'b1;
                            end else if (w_outXfer) begin
                                w_nextState = ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (w_outXfer) begin
                                w_nextState = ST_FULL;
                                w_promote   = 1'b1;
                            end
                        end
                        default: w_nextState = ST_EMPTY;
                    endcase
                end
            end

            // in_ready is registered from the next state so it never sees out_ready combinationally
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state   <= ST_EMPTY;
                    r_inReady <= 1'b1;
                end else begin
                    r_state   <= w_nextState;
                    r_inReady <= (w_nextState != ST_SKID);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mainCtrl <= CTRL_BUBBLE;
                    r_mainData <= '0;
                    r_skidCtrl <= '0;
                    r_skidData <= '0;
                end else begin
                    if (w_loadMain) begin
                        r_mainCtrl <= in_ctrl;
                        r_mainData <= in_data;
                    end else if (w_promote) begin
                        r_mainCtrl <= r_skidCtrl;
                        r_mainData <= r_skidData;
                    end
                    if (w_loadSkid) begin
                        r_skidCtrl <= in_ctrl;
                        r_skidData <= in_data;
                    end
                end
            end

            assign w_outValid = (r_state != ST_EMPTY);
            assign w_inReady  = r_inReady;
            assign w_mainCtrl = r_mainCtrl;
            assign w_mainData = r_mainData;
        end else begin : g_noskid
            logic              r_valid;
            logic [CTRL_W-1:0] r_mainCtrl;
            logic [DATA_W-1:0] r_mainData;
            logic              w_load;

            assign w_inReady = ~r_valid | out_ready;
            assign w_load    = in_valid & w_inReady & ~flush;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid    <= 1'b0;
                    r_mainCtrl <= CTRL_BUBBLE;
                    r_mainData <= '0;
                end else begin
                    if (flush) begin
                        r_valid <= 1'b0;
                    end else if (w_load) begin
                        r_valid <= 1'b1;
                    end else if (w_outXfer) begin
                        r_valid <= 1'b0;
                    end
                    if (w_load) begin
                        r_mainCtrl <= in_ctrl;
                        r_mainData <= in_data;
                    end
                end
            end

            assign w_outValid = r_valid;
            assign w_mainCtrl = r_mainCtrl;
            assign w_mainData = r_mainData;
        end
    endgenerate

    // Flush deliberately leaves the stall statistic untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (w_outValid && !out_ready && !(&r_stallCnt)) begin
            r_stallCnt <= r_stallCnt + STAT_W'(1);
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_ctrl  = w_outValid ? w_mainCtrl : CTRL_BUBBLE;
    assign out_data  = w_mainData;
    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Randomised and directed checks of pipe_stage_reg against a queue model.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 10;
    localparam int DW = 96;
    localparam logic [CW-1:0] BUB1 = 10'h3C3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          inReady0, outValid0, inReady1, outValid1;
    logic [CW-1:0] outCtrl0, outCtrl1;
    logic [DW-1:0] outData0, outData1;
    logic [15:0]   stall0;
    logic [1:0]    stall1;

    int total = 0;
    int bad = 0;

    logic [CW+DW-1:0] q0[$];
    logic [CW+DW-1:0] q1[$];
    logic [DW-1:0]    lastD0, lastD1;
    int               cnt0, cnt1;

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(outValid0), .out_ready(out_ready), .out_ctrl(outCtrl0),
        .out_data(outData0), .stall_cnt(stall0)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB1), .SKID(0), .STAT_W(2)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(outValid1), .out_ready(out_ready), .out_ctrl(outCtrl1),
        .out_data(outData1), .stall_cnt(stall1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        lastD0 = '0;
        lastD1 = '0;
        cnt0   = 0;
        cnt1   = 0;
    endtask

    // Skid stage holds up to two entries, plain stage one; both are FIFOs
    task automatic step_model();
        int sz0, sz1;
        bit ix0, ix1, ox0, ox1;
        logic [CW+DW-1:0] e;
        if (reset) begin
            model_clear();
            return;
        end
        sz0 = q0.size();
        sz1 = q1.size();
        ix0 = in_valid && (sz0 < 2) && !flush;
        ix1 = in_valid && (sz1 == 0 || out_ready) && !flush;
        ox0 = (sz0 > 0) && out_ready;
        ox1 = (sz1 > 0) && out_ready;
        if (sz0 > 0 && !out_ready && cnt0 < 65535) cnt0++;
        if (sz1 > 0 && !out_ready && cnt1 < 3) cnt1++;
        if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ox0) void'(q0.pop_front());
            if (ix0) q0.push_back({in_ctrl, in_data});
            if (ox1) void'(q1.pop_front());
            if (ix1) q1.push_back({in_ctrl, in_data});
        end
        if (q0.size() > 0) begin
            e = q0[0];
            lastD0 = e[DW-1:0];
        end
        if (q1.size() > 0) begin
            e = q1[0];
            lastD1 = e[DW-1:0];
        end
    endtask

    task automatic compare_outputs();
        logic [CW+DW-1:0] e;
        logic [CW-1:0]    c0, c1;
        c0 = '0;
        c1 = BUB1;
        if (q0.size() > 0) begin
            e  = q0[0];
            c0 = e[CW+DW-1:DW];
        end
        if (q1.size() > 0) begin
            e  = q1[0];
            c1 = e[CW+DW-1:DW];
        end
        chk("s_valid", outValid0, q0.size() > 0);
        chk("s_ready", inReady0, q0.size() < 2);
        chk("s_ctrl", outCtrl0, c0);
        chk("s_data", outData0, lastD0);
        chk("s_stall", stall0, cnt0);
        chk("p_valid", outValid1, q1.size() > 0);
        chk("p_ready", inReady1, (q1.size() == 0) || out_ready);
        chk("p_ctrl", outCtrl1, c1);
        chk("p_data", outData1, lastD1);
        chk("p_stall", stall1, cnt1);
    endtask

    task automatic check_reset_vals();
        chk("rst_s_valid", outValid0, 0);
        chk("rst_s_ctrl", outCtrl0, 0);
        chk("rst_s_data", outData0, 0);
        chk("rst_s_stall", stall0, 0);
        chk("rst_s_ready", inReady0, 1);
        chk("rst_p_valid", outValid1, 0);
        chk("rst_p_ctrl", outCtrl1, BUB1);
        chk("rst_p_data", outData1, 0);
        chk("rst_p_stall", stall1, 0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic cyc(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        compare_outputs();
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        reset_dut();

        // streaming with downstream always ready
        for (int i = 1; i <= 4; i++) cyc(1, 10'h2A5, DW'(i), 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("stream_stall", stall0, 0);

        // fill skid, then drain in order
        cyc(1, 10'h011, 96'hA, 0, 0);
        cyc(1, 10'h022, 96'hB, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("skid_ready_low", inReady0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("drain_b_head", outData0, 96'hB);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // flush while skid is full and new entry offered
        cyc(1, 10'h033, 96'hC1, 0, 0);
        cyc(1, 10'h044, 96'hC2, 0, 0);
        cyc(1, 10'h055, 96'hC3, 0, 1);
        chk("flush_valid", outValid0, 0);
        chk("flush_ready", inReady0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // stall counter, and saturation on the narrow counter
        reset_dut();
        cyc(1, 10'h066, 96'hD, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("stall5", stall0, 5);
        chk("stall_sat", stall1, 3);
        cyc(0, 0, 0, 1, 0);

        // back-to-back through the plain stage, then downstream blocks
        for (int i = 0; i < 6; i++) cyc(1, CW'(i + 1), DW'(100 + i), 1, 0);
        cyc(1, 10'h077, 96'h200, 0, 0);
        chk("p_ready_follows", inReady1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // asynchronous reset mid-cycle while skid is full
        cyc(1, 10'h088, 96'hE1, 0, 0);
        cyc(1, 10'h099, 96'hE2, 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // randomised traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 3) != 0), CW'($urandom), {$urandom, $urandom, $urandom},
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
